// File: rtl/float_div_seq.sv
// Sequential floating-point divider: restoring shift-subtract mantissa loop,
// truncating normalisation, flush-to-zero and saturate-to-max-finite.
module float_div_seq #(
    parameter int N_mantisse = 23,
    parameter int N_exposant = 8,
    localparam int W = 1 + N_exposant + N_mantisse
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         div_by_zero
);
    localparam int NM = N_mantisse;
    localparam int NE = N_exposant;
    localparam int QW = NM + 2;
    localparam int EW = NE + 2;
    localparam int CW = $clog2(NM + 3);
    localparam logic signed [EW-1:0] BIAS   = EW'((2 ** (NE - 1)) - 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1'b1);
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_OVF  = EW'((2 ** NE) - 1);
    localparam logic [NE-1:0]        E_MAXF = NE'((2 ** NE) - 2);
    localparam logic [CW-1:0]        ITERS  = CW'(NM + 2);
    localparam logic [CW-1:0]        C_ONE  = CW'(1'b1);

    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, NORM = 2'd2} state_t;

    state_t                 state_r;
    logic                   sign_r;
    logic                   z1_r;
    logic                   z2_r;
    logic signed [EW-1:0]   e_r;
    logic [QW-1:0]          rem_r;
    logic [NM:0]            dv_r;
    logic [QW-1:0]          q_r;
    logic [CW-1:0]          cnt_r;

    logic [QW-1:0]          diff_s;
    logic                   ge_s;
    logic [NM-1:0]          mant_s;
    logic signed [EW-1:0]   exp_s;
    logic [W-1:0]           res_s;
    logic                   dbz_s;

    function automatic logic [W-1:0] pack_float(input logic s, input logic [NE-1:0] ex,
                                                input logic [NM-1:0] m);
        return {s, ex, m};
    endfunction

    // Trial subtraction for the current quotient bit.
    always_comb begin
        diff_s = rem_r - {1'b0, dv_r};
        ge_s   = (rem_r >= {1'b0, dv_r});
    end

    // Normalise the quotient and pick the special-case result, first match wins.
    always_comb begin
        mant_s = '0;
        exp_s  = e_r;
        res_s  = '0;
        dbz_s  = 1'b0;
        if (q_r[NM+1]) begin
            mant_s = q_r[NM:1];
            exp_s  = e_r;
        end else begin
            mant_s = q_r[NM-1:0];
            exp_s  = e_r - E_ONE;
        end
        if (z2_r) begin
            res_s = pack_float(sign_r, E_MAXF, '1);
            dbz_s = 1'b1;
        end else if (z1_r) begin
            res_s = pack_float(sign_r, '0, '0);
        end else if (exp_s <= E_ZERO) begin
            res_s = pack_float(sign_r, '0, '0);
        end else if (exp_s >= E_OVF) begin
            res_s = pack_float(sign_r, E_MAXF, '1);
        end else begin
            res_s = pack_float(sign_r, exp_s[NE-1:0], mant_s);
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            sign_r      <= 1'b0;
            z1_r        <= 1'b0;
            z2_r        <= 1'b0;
            e_r         <= '0;
            rem_r       <= '0;
            dv_r        <= '0;
            q_r         <= '0;
            cnt_r       <= '0;
            ready       <= 1'b1;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sign_r  <= op1[W-1] ^ op2[W-1];
                        z1_r    <= (op1[W-2 -: NE] == '0);
                        z2_r    <= (op2[W-2 -: NE] == '0);
                        e_r     <= $signed({2'b00, op1[W-2 -: NE]})
                                 - $signed({2'b00, op2[W-2 -: NE]}) + BIAS;
                        rem_r   <= {1'b0, 1'b1, op1[NM-1:0]};
                        dv_r    <= {1'b1, op2[NM-1:0]};
                        q_r     <= '0;
                        cnt_r   <= ITERS;
                        ready   <= 1'b0;
                        state_r <= DIV;
                    end
                end
                DIV: begin
                    // The remainder stays below twice the divisor, so the shift never overflows.
                    if (ge_s) begin
                        rem_r <= {diff_s[QW-2:0], 1'b0};
                        q_r   <= {q_r[QW-2:0], 1'b1};
                    end else begin
                        rem_r <= {rem_r[QW-2:0], 1'b0};
                        q_r   <= {q_r[QW-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r - C_ONE;
                    if (cnt_r == C_ONE) begin
                        state_r <= NORM;
                    end
                end
                NORM: begin
                    result      <= res_s;
                    div_by_zero <= dbz_s;
                    done        <= 1'b1;
                    ready       <= 1'b1;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_float_div_seq.sv
// Directed self-checking bench for float_div_seq using the default 23/8 format.
module tb_float_div_seq;
    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;

    int checks;
    int errors;

    float_div_seq #(.N_mantisse(23), .N_exposant(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op1(op1), .op2(op2),
        .ready(ready), .done(done), .result(result), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at a negedge and wait (bounded) for done; returns at the done negedge.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_dbz);
        int lat;
        start = 1'b1;
        op1 = a;
        op2 = b;
        @(negedge clk);
        start = 1'b0;
        op1 = $urandom;
        op2 = $urandom;
        check({tag, "_busy"}, {31'd0, ready}, 32'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_lat"}, lat, 32'd26);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    endtask

    initial begin
        int ndone;
        int first_at;
        int second_at;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        start = 1'b0;
        op1 = '0;
        op2 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'h0000_0000);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
        run_op("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0);
        run_op("neg4_half", 32'hC080_0000, 32'h3F00_0000, 32'hC100_0000, 1'b0);
        run_op("dbz_pos", 32'h3F80_0000, 32'h0000_0000, 32'h7F7F_FFFF, 1'b1);
        run_op("dbz_neg", 32'hBF80_0000, 32'h0000_0000, 32'hFF7F_FFFF, 1'b1);
        run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7F7F_FFFF, 1'b1);
        run_op("underflow", 32'h0D80_0000, 32'h7180_0000, 32'h0000_0000, 1'b0);
        run_op("overflow", 32'h7180_0000, 32'h0D80_0000, 32'h7F7F_FFFF, 1'b0);
        run_op("zero_num", 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0);
        @(negedge clk);

        // start held for 40 cycles: accepted at E0 and again in the first done cycle.
        start = 1'b1;
        op1 = 32'h40C0_0000;
        op2 = 32'h4000_0000;
        ndone = 0;
        first_at = -1;
        second_at = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) first_at = i - 1;
                if (ndone == 2) second_at = i - 1;
            end
            if (i == 40) start = 1'b0;
        end
        check("hold_count", ndone, 32'd2);
        check("hold_first", first_at, 32'd26);
        check("hold_second", second_at, 32'd53);
        check("hold_res", result, 32'h4040_0000);

        // Start pulses while busy must be ignored.
        start = 1'b1;
        op1 = 32'h3F80_0000;
        op2 = 32'h4040_0000;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first_at = -1;
        for (int i = 1; i <= 70; i++) begin
            if (i == 5 || i == 10) begin
                start = 1'b1;
                op1 = 32'h3F80_0000;
                op2 = 32'h0000_0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    first_at = i;
                    check("busy_res", result, 32'h3EAA_AAAA);
                    check("busy_dbz", {31'd0, div_by_zero}, 32'd0);
                end
            end
        end
        start = 1'b0;
        check("busy_count", ndone, 32'd1);
        check("busy_lat", first_at, 32'd26);

        // Reset during iteration 12 aborts the operation silently.
        start = 1'b1;
        op1 = 32'h40C0_0000;
        op2 = 32'h4000_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_busy", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_ready", {31'd0, ready}, 32'd1);
        check("mid_result", result, 32'h0000_0000);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("mid_nodone", ndone, 32'd0);
        run_op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
